// File: rtl/rdmap_hdr_arbiter_pkg.sv
// Shared constants and types for the RDMAP header-path arbiter.
package rdmap_pkg;

  localparam int unsigned NUM_CLASS = 4;
  localparam int unsigned CTRL_W    = 16;
  localparam int unsigned WR_W      = 52;

  // Requester class indices; lower index wins under fixed priority.
  localparam int unsigned CLS_ACK  = 0;
  localparam int unsigned CLS_REQ  = 1;
  localparam int unsigned CLS_RCV  = 2;
  localparam int unsigned CLS_SEND = 3;

  // Opcodes forced into the low byte of the issued control word.
  localparam logic [7:0] OP_SEND = 8'h00;
  localparam logic [7:0] OP_RCV  = 8'h01;
  localparam logic [7:0] OP_REQ  = 8'h03;
  localparam logic [7:0] OP_ACK  = 8'h07;

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } arb_state_e;

  function automatic logic [7:0] class_opcode(input int unsigned idx);
    logic [7:0] op;
    case (idx)
      CLS_ACK: op = OP_ACK;
      CLS_REQ: op = OP_REQ;
      CLS_RCV: op = OP_RCV;
      default: op = OP_SEND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rdmap_hdr_arbiter_if.sv
// Request and issue bus between requesters, the arbiter and the header generator.
interface rdmap_hdr_arbiter_if;
  import rdmap_pkg::*;

  logic [NUM_CLASS-1:0]        reqValid;
  logic [NUM_CLASS*CTRL_W-1:0] reqControl;
  logic [NUM_CLASS*WR_W-1:0]   reqWR;
  logic [NUM_CLASS-1:0]        reqGrant;
  logic                        poolFull;
  logic                        hdrTaken;
  logic                        flush;
  logic                        infoValid;
  logic [CTRL_W-1:0]           rdmaControl;
  logic [WR_W-1:0]             rdmaWR;
  logic                        flushDone;
  logic                        creditErr;

  // Requester / environment side.
  modport master (
    output reqValid, reqControl, reqWR, poolFull, hdrTaken, flush,
    input  reqGrant, infoValid, rdmaControl, rdmaWR, flushDone, creditErr
  );

  // Arbiter side.
  modport slave (
    input  reqValid, reqControl, reqWR, poolFull, hdrTaken, flush,
    output reqGrant, infoValid, rdmaControl, rdmaWR, flushDone, creditErr
  );

endinterface

// File: rtl/rdmap_hdr_arbiter_prio_pick.sv
// Fixed-priority one-hot picker; when forced, picks the lowest-priority eligible class.
module rdmap_prio_pick
  import rdmap_pkg::*;
(
  input  logic [NUM_CLASS-1:0] i_eligible,
  input  logic                 i_force,
  output logic [NUM_CLASS-1:0] o_grant
);

  logic w_found;

  // Scan from the high-priority end normally, from the low-priority end when forced.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    if (i_force) begin
      for (int i = NUM_CLASS - 1; i >= 0; i--) begin
        if (i_eligible[i] && !w_found) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (i_eligible[i] && !w_found) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rdmap_hdr_arbiter.sv
// Arbitrates four requester classes onto the RDMAP header-generation issue bus,
// with DDP credit tracking, ACK gating on pool-full, starvation override and flush/drain.
module rdmap_hdr_arbiter
  import rdmap_pkg::*;
#(
  parameter int unsigned CREDITS      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic                clock,
  input logic                reset,
  rdmap_hdr_arbiter_if.slave bus
);

  localparam int unsigned   CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [7:0]    LOSE_MAX = 8'(STARVE_LIMIT);

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic [CW-1:0]        r_credits;
  logic [CW-1:0]        w_credits_next;
  logic [7:0]           r_lose_cnt;
  logic [7:0]           w_lose_next;
  logic                 r_info_valid;
  logic [CTRL_W-1:0]    r_rdma_control;
  logic [WR_W-1:0]      r_rdma_wr;
  logic                 r_flush_done;
  logic                 w_done_next;
  logic                 r_credit_err;
  logic                 w_err_set;

  logic                 w_run_ok;
  logic [NUM_CLASS-1:0] w_eligible;
  logic [NUM_CLASS-1:0] w_grant;
  logic                 w_force;
  logic                 w_any_grant;
  logic                 w_lower_wait;
  logic [CTRL_W-1:0]    w_issue_ctrl;
  logic [WR_W-1:0]      w_issue_wr;
  logic                 w_unused_ctrl_lo;

  // Low control bytes are replaced by the forced opcode and never consumed.
  always_comb begin
    w_unused_ctrl_lo = 1'b0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      w_unused_ctrl_lo = w_unused_ctrl_lo ^ (^bus.reqControl[CTRL_W*i +: 8]);
    end
  end

  // Eligibility: running, not flushing this cycle, credit available; ACK also needs pool room.
  always_comb begin
    w_run_ok            = (r_state == StRun) && !bus.flush && (r_credits != '0);
    w_eligible          = bus.reqValid & {NUM_CLASS{w_run_ok}};
    w_eligible[CLS_ACK] = w_eligible[CLS_ACK] & ~bus.poolFull;
  end

  assign w_force = (r_lose_cnt == LOSE_MAX);

  rdmap_prio_pick u_pick (
    .i_eligible (w_eligible),
    .i_force    (w_force),
    .o_grant    (w_grant)
  );

  assign w_any_grant  = |w_grant;
  assign bus.reqGrant = w_grant;

  // Detect an eligible class below the winner that lost this cycle.
  always_comb begin
    w_lower_wait = 1'b0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      for (int j = i + 1; j < NUM_CLASS; j++) begin
        if (w_grant[i] && w_eligible[j]) begin
          w_lower_wait = 1'b1;
        end
      end
    end
  end

  // Select the granted class's payload and force its opcode.
  always_comb begin
    w_issue_ctrl = '0;
    w_issue_wr   = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (w_grant[i]) begin
        w_issue_ctrl = {bus.reqControl[CTRL_W*i+8 +: 8], class_opcode(i)};
        w_issue_wr   = bus.reqWR[WR_W*i +: WR_W];
      end
    end
  end

  // Credit next state: grant spends, hdrTaken returns, overflow saturates and flags.
  always_comb begin
    w_credits_next = r_credits;
    w_err_set      = 1'b0;
    if (w_any_grant && !bus.hdrTaken) begin
      w_credits_next = r_credits - CRED_ONE;
    end else if (!w_any_grant && bus.hdrTaken) begin
      if (r_credits == CRED_MAX) begin
        w_err_set = 1'b1;
      end else begin
        w_credits_next = r_credits + CRED_ONE;
      end
    end
  end

  // Starvation counter next state; held on cycles without a grant.
  always_comb begin
    w_lose_next = r_lose_cnt;
    if (w_any_grant) begin
      if (w_force || !w_lower_wait) begin
        w_lose_next = '0;
      end else begin
        w_lose_next = r_lose_cnt + 8'd1;
      end
    end
  end

  // FSM next state and drain-complete pulse.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      StRun: begin
        if (bus.flush) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (r_credits == CRED_MAX) begin
          w_state_next = StRun;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = StRun;
    endcase
  end

  // FSM state, flush-done pulse and sticky credit error.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StRun;
      r_flush_done <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_done <= w_done_next;
      r_credit_err <= r_credit_err | w_err_set;
    end
  end

  // Credit and starvation counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_credits  <= CRED_MAX;
      r_lose_cnt <= '0;
    end else begin
      r_credits  <= w_credits_next;
      r_lose_cnt <= w_lose_next;
    end
  end

  // Issue registers; payload holds when nothing is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_info_valid   <= 1'b0;
      r_rdma_control <= '0;
      r_rdma_wr      <= '0;
    end else begin
      r_info_valid <= w_any_grant;
      if (w_any_grant) begin
        r_rdma_control <= w_issue_ctrl;
        r_rdma_wr      <= w_issue_wr;
      end
    end
  end

  assign bus.infoValid   = r_info_valid;
  assign bus.rdmaControl = r_rdma_control;
  assign bus.rdmaWR      = r_rdma_wr;
  assign bus.flushDone   = r_flush_done;
  assign bus.creditErr   = r_credit_err;

endmodule

// File: tb/tb_rdmap_hdr_arbiter.sv
// Directed bench: stimulus pushes expected issues into a queue, a monitor pops on infoValid.
module tb_rdmap_hdr_arbiter;

  typedef struct {
    logic [15:0] ctrl;
    logic [51:0] wr;
  } exp_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t q[$];
  logic [7:0] op_tab [4];

  rdmap_hdr_arbiter_if bus ();

  rdmap_hdr_arbiter #(
    .CREDITS      (4),
    .STARVE_LIMIT (8)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every issue strobe must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.infoValid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got ctrl %h wr %h want no issue",
                 bus.rdmaControl, bus.rdmaWR);
      end else begin
        e = q.pop_front();
        if (bus.rdmaControl !== e.ctrl || bus.rdmaWR !== e.wr) begin
          n_err++;
          $display("FAIL issue_data: got ctrl %h wr %h want ctrl %h wr %h",
                   bus.rdmaControl, bus.rdmaWR, e.ctrl, e.wr);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // One cycle: check grant and flushDone before the edge, queue expected issue.
  task automatic step(input logic [3:0] exp_g, input logic exp_fd, input string nm);
    exp_t e;
    @(negedge clock);
    chk({nm, "_grant"}, 64'(bus.reqGrant), 64'(exp_g));
    chk({nm, "_flushDone"}, 64'(bus.flushDone), 64'(exp_fd));
    for (int i = 0; i < 4; i++) begin
      if (exp_g[i]) begin
        e.ctrl = {bus.reqControl[16*i+8 +: 8], op_tab[i]};
        e.wr   = bus.reqWR[52*i +: 52];
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < 4; i++) begin
      bus.reqControl[16*i +: 16] = 16'($urandom);
      bus.reqWR[52*i +: 52]      = {20'($urandom), 32'($urandom)};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    op_tab[0] = 8'h07;
    op_tab[1] = 8'h03;
    op_tab[2] = 8'h01;
    op_tab[3] = 8'h00;
    bus.reqValid = '0;
    bus.poolFull = 1'b0;
    bus.hdrTaken = 1'b0;
    bus.flush    = 1'b0;
    new_data();
    do_reset();

    // Reset state.
    chk("rst_infoValid", 64'(bus.infoValid), 64'd0);
    chk("rst_rdmaControl", 64'(bus.rdmaControl), 64'd0);
    chk("rst_rdmaWR", 64'(bus.rdmaWR), 64'd0);
    chk("rst_flushDone", 64'(bus.flushDone), 64'd0);
    chk("rst_creditErr", 64'(bus.creditErr), 64'd0);

    // All four classes: priority order, then credits exhausted.
    bus.reqValid = 4'b1111;
    step(4'b0001, 1'b0, "t1_ack");
    bus.reqValid[0] = 1'b0;
    step(4'b0010, 1'b0, "t1_req");
    bus.reqValid[1] = 1'b0;
    step(4'b0100, 1'b0, "t1_rcv");
    bus.reqValid[2] = 1'b0;
    step(4'b1000, 1'b0, "t1_send");
    bus.reqValid = 4'b0001;
    step(4'b0000, 1'b0, "t1_nocredit");
    bus.reqValid = 4'b0000;

    // Grant and hdrTaken together at credits=1 leave one credit.
    bus.hdrTaken = 1'b1;
    step(4'b0000, 1'b0, "t4_ret1");
    new_data();
    bus.reqValid = 4'b0010;
    step(4'b0010, 1'b0, "t4_both");
    bus.reqValid = 4'b0100;
    bus.hdrTaken = 1'b0;
    step(4'b0100, 1'b0, "t4_last");
    bus.reqValid = 4'b1000;
    step(4'b0000, 1'b0, "t4_empty");
    bus.hdrTaken = 1'b1;
    step(4'b0000, 1'b0, "t4_retcyc");
    bus.hdrTaken = 1'b0;
    step(4'b1000, 1'b0, "t4_nextcyc");
    bus.reqValid = 4'b0000;
    bus.hdrTaken = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, "t4_refill");
    chk("t4_err_before", 64'(bus.creditErr), 64'd0);
    step(4'b0000, 1'b0, "t4_over");
    bus.hdrTaken = 1'b0;
    chk("t4_err_set", 64'(bus.creditErr), 64'd1);
    step(4'b0000, 1'b0, "t4_idle");
    chk("t4_err_sticky", 64'(bus.creditErr), 64'd1);

    // Starvation: ACK 8 times then SEND once, repeating.
    do_reset();
    chk("t2_err_cleared", 64'(bus.creditErr), 64'd0);
    new_data();
    bus.reqValid = 4'b1001;
    bus.hdrTaken = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) step(4'b0001, 1'b0, "t2_ack");
      step(4'b1000, 1'b0, "t2_send");
    end
    bus.reqValid = 4'b0000;
    bus.hdrTaken = 1'b0;
    step(4'b0000, 1'b0, "t2_idle");
    chk("t2_no_err", 64'(bus.creditErr), 64'd0);

    // poolFull blocks ACK in the same cycle.
    new_data();
    bus.poolFull = 1'b1;
    bus.reqValid = 4'b0101;
    step(4'b0100, 1'b0, "t3_rcv");
    bus.reqValid = 4'b0001;
    step(4'b0000, 1'b0, "t3_ack_held");
    bus.poolFull = 1'b0;
    step(4'b0001, 1'b0, "t3_ack");
    bus.reqValid = 4'b0000;

    // Flush with 3 credits outstanding.
    bus.reqValid = 4'b0010;
    step(4'b0010, 1'b0, "t5_req");
    bus.reqValid = 4'b1000;
    bus.flush = 1'b1;
    step(4'b0000, 1'b0, "t5_flushcyc");
    bus.flush = 1'b0;
    step(4'b0000, 1'b0, "t5_drain");
    bus.hdrTaken = 1'b1;
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "t5_ret");
    bus.hdrTaken = 1'b0;
    step(4'b0000, 1'b0, "t5_full");
    step(4'b1000, 1'b1, "t5_done");
    bus.reqValid = 4'b0000;
    step(4'b0000, 1'b0, "t5_after");

    // Reset in the middle of a drain.
    bus.flush = 1'b1;
    step(4'b0000, 1'b0, "t6_flush");
    bus.flush = 1'b0;
    step(4'b0000, 1'b0, "t6_drain");
    reset = 1'b1;
    step(4'b0000, 1'b0, "t6_rst");
    step(4'b0000, 1'b0, "t6_rst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "t6_nodone");
    new_data();
    bus.reqValid = 4'b1111;
    step(4'b0001, 1'b0, "t6_ack");
    bus.reqValid[0] = 1'b0;
    step(4'b0010, 1'b0, "t6_req");
    bus.reqValid[1] = 1'b0;
    step(4'b0100, 1'b0, "t6_rcv");
    bus.reqValid[2] = 1'b0;
    step(4'b1000, 1'b0, "t6_send");
    bus.reqValid = 4'b0001;
    step(4'b0000, 1'b0, "t6_nocredit");
    bus.reqValid = 4'b0000;
    step(4'b0000, 1'b0, "t6_idle");

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
